// File: rtl/div_pkg.sv
// Shared types and result fix-up for the integer divide issue path.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } div_state_t;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // RISC-V special-case result select. op[1] picks remainder, op[0] picks unsigned.
  // Overflow only exists for the signed forms, so it is ignored for DIVU/REMU.
  function automatic logic [31:0] div_fixup(input div_op_t     op,
                                            input logic        dbz,
                                            input logic        ovf,
                                            input logic [31:0] rs1,
                                            input logic [31:0] val,
                                            input logic [31:0] rem);
    logic is_rem;
    logic is_signed;
    is_rem    = op[1];
    is_signed = !op[0];
    if (dbz) begin
      div_fixup = is_rem ? rs1 : ALL_ONES;
    end else if (ovf && is_signed) begin
      div_fixup = is_rem ? 32'h0 : INT_MIN;
    end else begin
      div_fixup = is_rem ? rem : val;
    end
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Bundles issue, divider and writeback signals of the divide issue controller.
// Latency: n/a (wiring only).
// Backpressure: issue and writeback are valid/ready; divider side is start/done.
interface div_issue_ctrl_if #(
  parameter int TAG_W = 6
);
  // issue port
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [31:0]      issue_rs1;
  logic [31:0]      issue_rs2;
  logic [TAG_W-1:0] issue_tag;
  // divider port
  logic             div_start;
  logic             div_unsigned;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_busy;
  logic             div_done;
  logic             div_dbz;
  logic             div_overflow;
  logic [31:0]      div_val;
  logic [31:0]      div_rem;
  // writeback port
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;

  // controller side
  modport master (
    input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_tag,
    output issue_ready,
    output div_start, div_unsigned, div_a, div_b,
    input  div_busy, div_done, div_dbz, div_overflow, div_val, div_rem,
    output wb_valid, wb_tag, wb_data,
    input  wb_ready
  );

  // issuing pipeline, divider and writeback consumer side
  modport slave (
    output issue_valid, issue_op, issue_rs1, issue_rs2, issue_tag,
    input  issue_ready,
    input  div_start, div_unsigned, div_a, div_b,
    output div_busy, div_done, div_dbz, div_overflow, div_val, div_rem,
    input  wb_valid, wb_tag, wb_data,
    output wb_ready
  );

endinterface

// File: rtl/div_issue_ctrl.sv
// Issues one DIV/DIVU/REM/REMU at a time to the iterative divider and writes back the fixed-up result.
// Latency: result valid 35 cycles after acceptance (3 for divide-by-zero/overflow).
// Backpressure: issue_ready only in IDLE; result held in RESP until wb_ready; flush drains the divider.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  div_issue_ctrl_if.master   bus
);

  div_state_t       state_q;
  div_state_t       state_next;
  div_op_t          op_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic             issue_ready;
  logic             accept;
  logic             capture;

  assign issue_ready = (state_q == IDLE) && !flush_i;
  assign accept      = issue_ready && bus.issue_valid;
  // A result is only captured when it will actually be written back.
  assign capture     = (state_q == WAIT) && bus.div_done && !flush_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_next = START;
        end
      end
      START: begin
        // Start pulse goes out regardless; a flush here must still drain the divider.
        state_next = flush_i ? DRAIN : WAIT;
      end
      WAIT: begin
        if (flush_i) begin
          state_next = bus.div_done ? IDLE : DRAIN;
        end else if (bus.div_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (flush_i || bus.wb_ready) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (bus.div_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/tag capture at acceptance and result capture at divider completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= DIV;
      rs1_q  <= '0;
      rs2_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= div_op_t'(bus.issue_op);
        rs1_q <= bus.issue_rs1;
        rs2_q <= bus.issue_rs2;
        tag_q <= bus.issue_tag;
      end
      if (capture) begin
        data_q <= div_fixup(op_q, bus.div_dbz, bus.div_overflow, rs1_q,
                            bus.div_val, bus.div_rem);
      end
    end
  end

  assign bus.issue_ready  = issue_ready;
  assign bus.div_start    = (state_q == START);
  assign bus.div_unsigned = op_q[0];
  assign bus.div_a        = rs1_q;
  assign bus.div_b        = rs2_q;
  assign bus.wb_valid     = (state_q == RESP);
  assign bus.wb_tag       = tag_q;
  assign bus.wb_data      = data_q;

  // The divider shares our reset and is always drained before IDLE, so it can never be busy here.
  a_idle_not_busy: assert property (@(posedge clk) disable iff (rst)
                                    (state_q == IDLE) |-> !bus.div_busy);

endmodule
